// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing ALU sequencer: opcodes, condition codes,
// FSM states, NZCV bit positions and the opcode-to-ALU mapping.
package dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COND = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } dp_state_e;

    // TST/TEQ/CMP/CMN: flags only, never a register write
    function automatic logic is_test_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // The ALU only implements the writing forms; test ops borrow their arithmetic twin
    function automatic logic [3:0] alu_op_map(input logic [3:0] op);
        case (op)
            OP_TST:  return OP_AND;
            OP_TEQ:  return OP_EOR;
            OP_CMP:  return OP_SUB;
            OP_CMN:  return OP_ADD;
            default: return op;
        endcase
    endfunction

endpackage

// File: rtl/dp_alu_seq_if.sv
// Instruction handshake bus from decode/shifter into the ALU sequencer.
interface dp_alu_seq_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cond;
    logic [3:0]        in_opcode;
    logic              in_s;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_shc;

    modport master (
        output in_valid, in_cond, in_opcode, in_s, in_rd, in_a, in_b, in_shc,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_cond, in_opcode, in_s, in_rd, in_a, in_b, in_shc,
        output in_ready
    );
endinterface

// File: rtl/dp_cond_chk.sv
// ARM condition-field evaluation against the NZCV flags; purely combinational.
module dp_cond_chk
    import dp_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);
    logic n, z, c, v;

    assign n = nzcv_i[NZCV_N];
    assign z = nzcv_i[NZCV_Z];
    assign c = nzcv_i[NZCV_C];
    assign v = nzcv_i[NZCV_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            CC_EQ: pass_o = z;
            CC_NE: pass_o = ~z;
            CC_CS: pass_o = c;
            CC_CC: pass_o = ~c;
            CC_MI: pass_o = n;
            CC_PL: pass_o = ~n;
            CC_VS: pass_o = v;
            CC_VC: pass_o = ~v;
            CC_HI: pass_o = c & ~z;
            CC_LS: pass_o = ~c | z;
            CC_GE: pass_o = (n == v);
            CC_LT: pass_o = (n != v);
            CC_GT: pass_o = ~z & (n == v);
            CC_LE: pass_o = z | (n != v);
            CC_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/dp_alu_seq.sv
// Multi-cycle sequencer for one ARM data-processing instruction: COND, EXEC, WB.
// Define DP_PERF_CNT_EN to add the cnt_exec/cnt_skip performance counters.
module dp_alu_seq
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
`ifdef DP_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    dp_alu_seq_if.slave       in_if,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_shc,
    output logic              alu_cf,
    output logic              alu_vf,
    input  logic [DATA_W-1:0] alu_f,
    input  logic [3:0]        alu_nzcv,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        nzcv,
    output logic              busy
`ifdef DP_PERF_CNT_EN
    , output logic [CNT_W-1:0] cnt_exec
    , output logic [CNT_W-1:0] cnt_skip
`endif
);
    dp_state_e         state_q;
    logic              in_ready_q;
    logic [3:0]        cond_q;
    logic [3:0]        opc_q;
    logic              s_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              shc_q;
    logic [3:0]        flg_q;
    logic [3:0]        nzcv_q;
    logic              wb_en_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              cond_pass;

    dp_cond_chk u_cond (
        .cond_i (cond_q),
        .nzcv_i (nzcv_q),
        .pass_o (cond_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            cond_q     <= '0;
            opc_q      <= '0;
            s_q        <= 1'b0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            shc_q      <= 1'b0;
            flg_q      <= '0;
            nzcv_q     <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_if.in_valid) begin
                        cond_q     <= in_if.in_cond;
                        opc_q      <= in_if.in_opcode;
                        s_q        <= in_if.in_s;
                        rd_q       <= in_if.in_rd;
                        a_q        <= in_if.in_a;
                        b_q        <= in_if.in_b;
                        shc_q      <= in_if.in_shc;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_COND;
                    end
                end
                ST_COND: begin
                    if (cond_pass) begin
                        state_q <= ST_EXEC;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                // ALU has settled on the held operands; capture result and flags here
                ST_EXEC: begin
                    flg_q <= alu_nzcv;
                    if (!is_test_op(opc_q)) begin
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= rd_q;
                        wb_data_q <= alu_f;
                    end
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    if (s_q || is_test_op(opc_q)) begin
                        nzcv_q <= flg_q;
                    end
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign busy           = ~in_ready_q;
    assign alu_op         = alu_op_map(opc_q);
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_shc        = shc_q;
    assign alu_cf         = nzcv_q[NZCV_C];
    assign alu_vf         = nzcv_q[NZCV_V];
    assign wb_en          = wb_en_q;
    assign wb_addr        = wb_addr_q;
    assign wb_data        = wb_data_q;
    assign nzcv           = nzcv_q;

`ifdef DP_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_exec_q, cnt_exec_d;
    logic [CNT_W-1:0] cnt_skip_q, cnt_skip_d;

    // Saturating: counters stick at all-ones instead of wrapping
    always_comb begin
        cnt_exec_d = cnt_exec_q;
        cnt_skip_d = cnt_skip_q;
        if (state_q == ST_EXEC && cnt_exec_q != '1) begin
            cnt_exec_d = cnt_exec_q + CNT_W'(1);
        end
        if (state_q == ST_COND && !cond_pass && cnt_skip_q != '1) begin
            cnt_skip_d = cnt_skip_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_exec_q <= '0;
            cnt_skip_q <= '0;
        end else begin
            cnt_exec_q <= cnt_exec_d;
            cnt_skip_q <= cnt_skip_d;
        end
    end

    assign cnt_exec = cnt_exec_q;
    assign cnt_skip = cnt_skip_q;
`endif

endmodule
